mux_sync_tx_sched: RTL

//  Source-domain (clka) scheduler for the mux-recirculation CDC channel (en/data -> ndff en -> mux load).

---
 rtl/mux_sync_tx_sched.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mux_sync_tx_sched.sv
// Source-domain scheduler for the mux-recirculation CDC channel: round-robin grant among N_REQ
// requesters, each word held on en/data for HOLD_CYC cycles, then GAP_CYC cycles of quiet.
module mux_sync_tx_sched #(
    parameter int N_REQ    = 4,
    parameter int DW       = 8,
    parameter int HOLD_CYC = 9,
    parameter int GAP_CYC  = 6,
    localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clka,
    input  logic                rstn,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic                en,
    output logic [DW-1:0]       data,
    output logic                busy,
    output logic [IDW-1:0]      last_id
);

    localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             en_q, en_d;
    logic [DW-1:0]    data_q, data_d;
    logic             busy_q, busy_d;
    logic [IDW-1:0]   last_id_q, last_id_d;

    logic [DW-1:0]    word [N_REQ];
    logic             req_any;
    logic [IDW-1:0]   win;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign word[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    // Search last_id+1, last_id+2, ... ; iterating from the far end lets the nearest hit win.
    always_comb begin
        int idx;
        idx     = 0;
        req_any = 1'b0;
        win     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_id_q) + k) % N_REQ;
            if (req[idx[IDW-1:0]]) begin
                req_any = 1'b1;
                win     = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        en_d      = en_q;
        data_d    = data_q;
        busy_d    = busy_q;
        last_id_d = last_id_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d    = ST_HOLD;
                    cnt_d      = CW'(1);
                    gnt_d[win] = 1'b1;
                    en_d       = 1'b1;
                    data_d     = word[win];
                    busy_d     = 1'b1;
                    last_id_d  = win;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CW'(HOLD_CYC)) begin
                    state_d = ST_GAP;
                    cnt_d   = CW'(1);
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                // data is left untouched here so the far side never sees it move under a live sync path
                if (cnt_q == CW'(GAP_CYC)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gnt_q     <= '0;
            en_q      <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            last_id_q <= IDW'(N_REQ - 1);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            en_q      <= en_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            last_id_q <= last_id_d;
        end
    end

    assign gnt     = gnt_q;
    assign en      = en_q;
    assign data    = data_q;
    assign busy    = busy_q;
    assign last_id = last_id_q;

endmodule
